// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   DM_WORDS_DEF : default data-memory depth in 32-bit words
//   store_e      : store-type encoding carried from EX (none / word / half / byte)
package mem_stage_pkg;

    localparam int DM_WORDS_DEF = 1024;

    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_SW   = 2'b01,
        ST_SH   = 2'b10,
        ST_SB   = 2'b11
    } store_e;

endpackage

// File: rtl/dm_ram.sv
// Data memory: WORDS x 32-bit, one write port with 4 byte enables and an
// asynchronous (combinational) read on the same address.
// Ports:
//   clk    : clock
//   reset  : synchronous active-high; clears every word, blocks writes
//   we     : write enable
//   be     : byte-lane enables, bit n covers wdata[8n+7:8n]
//   addr   : word index (read and write)
//   wdata  : write data, already replicated onto the enabled lanes
//   rdata  : word currently stored at addr
module dm_ram
    import mem_stage_pkg::*;
#(
    parameter int WORDS = DM_WORDS_DEF,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    // One byte-wide array per lane, so each lane has a single writer and the
    // byte enables map directly onto independent write strobes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] r_lane [WORDS];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int w = 0; w < WORDS; w++) begin
                        r_lane[w] <= 8'h00;
                    end
                end else if (we && be[gi]) begin
                    r_lane[addr] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = r_lane[addr];
        end
    endgenerate

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM latch, store-data forwarding from WB,
// byte-enable generation and the data memory.
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   stall            : hold the latch, suppress the memory write
//   flush            : load a bubble into the latch (current store still writes)
//   *_ex             : control/data from EX, captured into the latch
//   RegWrite_wb, a3_wb, wd_wb : WB write-back, used to forward store data
//   *_mem            : latched EX/MEM fields
//   dmout_mem        : raw word at aluout_mem[11:2], same cycle as aluout_mem
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int DM_WORDS = DM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        RegWrite_ex,
    input  logic [1:0]  MemtoReg_ex,
    input  logic [2:0]  Load_ex,
    input  logic [1:0]  Store_ex,
    input  logic [31:0] aluout_ex,
    input  logic [31:0] rtdata_ex,
    input  logic [4:0]  rt_ex,
    input  logic [4:0]  a3_ex,
    input  logic [29:0] pc_ex,
    input  logic        RegWrite_wb,
    input  logic [4:0]  a3_wb,
    input  logic [31:0] wd_wb,
    output logic        RegWrite_mem,
    output logic [1:0]  MemtoReg_mem,
    output logic [2:0]  Load_mem,
    output logic [4:0]  a3_mem,
    output logic [29:0] pc_mem,
    output logic [31:0] aluout_mem,
    output logic [31:0] dmout_mem
);

    localparam int AW = $clog2(DM_WORDS);

    logic        r_regwrite;
    logic [1:0]  r_memtoreg;
    logic [2:0]  r_load;
    store_e      r_store;
    logic [31:0] r_aluout;
    logic [31:0] r_rtdata;
    logic [4:0]  r_rt;
    logic [4:0]  r_a3;
    logic [29:0] r_pc;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_regwrite <= 1'b0;
            r_memtoreg <= 2'b00;
            r_load     <= 3'b000;
            r_store    <= ST_NONE;
            r_aluout   <= 32'h0;
            r_rtdata   <= 32'h0;
            r_rt       <= 5'd0;
            r_a3       <= 5'd0;
            r_pc       <= 30'h0;
        end else if (!stall) begin
            r_regwrite <= RegWrite_ex;
            r_memtoreg <= MemtoReg_ex;
            r_load     <= Load_ex;
            r_store    <= store_e'(Store_ex);
            r_aluout   <= aluout_ex;
            r_rtdata   <= rtdata_ex;
            r_rt       <= rt_ex;
            r_a3       <= a3_ex;
            r_pc       <= pc_ex;
        end
    end

    // The store's source register may be written back in the same cycle the
    // store sits in MEM; r0 is never a real producer.
    logic        w_fwd;
    logic [31:0] w_sdata;
    assign w_fwd   = RegWrite_wb && (a3_wb != 5'd0) && (a3_wb == r_rt);
    assign w_sdata = w_fwd ? wd_wb : r_rtdata;

    // Data is replicated across lanes; the byte enables pick the target lanes.
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = w_sdata;
        case (r_store)
            ST_SW: begin
                w_be    = 4'b1111;
                w_wdata = w_sdata;
            end
            ST_SH: begin
                w_be    = r_aluout[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{w_sdata[15:0]}};
            end
            ST_SB: begin
                w_be    = 4'b0001 << r_aluout[1:0];
                w_wdata = {4{w_sdata[7:0]}};
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = w_sdata;
            end
        endcase
    end

    // Flush does not cancel the instruction already in MEM; only stall does.
    logic w_we;
    assign w_we = (r_store != ST_NONE) && !stall;

    dm_ram #(
        .WORDS (DM_WORDS),
        .AW    (AW)
    ) u_dm_ram (
        .clk   (clk),
        .reset (reset),
        .we    (w_we),
        .be    (w_be),
        .addr  (r_aluout[2 +: AW]),
        .wdata (w_wdata),
        .rdata (dmout_mem)
    );

    assign RegWrite_mem = r_regwrite;
    assign MemtoReg_mem = r_memtoreg;
    assign Load_mem     = r_load;
    assign a3_mem       = r_a3;
    assign pc_mem       = r_pc;
    assign aluout_mem   = r_aluout;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of latch and memory.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        RegWrite_ex;
    logic [1:0]  MemtoReg_ex;
    logic [2:0]  Load_ex;
    logic [1:0]  Store_ex;
    logic [31:0] aluout_ex, rtdata_ex;
    logic [4:0]  rt_ex, a3_ex;
    logic [29:0] pc_ex;
    logic        RegWrite_wb;
    logic [4:0]  a3_wb;
    logic [31:0] wd_wb;
    logic        RegWrite_mem;
    logic [1:0]  MemtoReg_mem;
    logic [2:0]  Load_mem;
    logic [4:0]  a3_mem;
    logic [29:0] pc_mem;
    logic [31:0] aluout_mem, dmout_mem;

    mem_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .RegWrite_ex  (RegWrite_ex),
        .MemtoReg_ex  (MemtoReg_ex),
        .Load_ex      (Load_ex),
        .Store_ex     (Store_ex),
        .aluout_ex    (aluout_ex),
        .rtdata_ex    (rtdata_ex),
        .rt_ex        (rt_ex),
        .a3_ex        (a3_ex),
        .pc_ex        (pc_ex),
        .RegWrite_wb  (RegWrite_wb),
        .a3_wb        (a3_wb),
        .wd_wb        (wd_wb),
        .RegWrite_mem (RegWrite_mem),
        .MemtoReg_mem (MemtoReg_mem),
        .Load_mem     (Load_mem),
        .a3_mem       (a3_mem),
        .pc_mem       (pc_mem),
        .aluout_mem   (aluout_mem),
        .dmout_mem    (dmout_mem)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_txn    = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference model state: what the EX/MEM latch and the memory should hold.
    logic        m_rw;
    logic [1:0]  m_mtr;
    logic [2:0]  m_ld;
    logic [1:0]  m_st;
    logic [31:0] m_alu, m_rtd;
    logic [4:0]  m_rt, m_a3;
    logic [29:0] m_pc;
    logic [31:0] m_mem [1024];

    task automatic model_bubble();
        m_rw = 0; m_mtr = 0; m_ld = 0; m_st = 0;
        m_alu = 0; m_rtd = 0; m_rt = 0; m_a3 = 0; m_pc = 0;
    endtask

    // Apply one clock edge's worth of behaviour using the current inputs.
    task automatic model_edge();
        logic [31:0] data;
        int idx;
        if (reset) begin
            model_bubble();
            for (int w = 0; w < 1024; w++) m_mem[w] = 32'h0;
            return;
        end
        if (m_st != 2'b00 && !stall) begin
            data = (RegWrite_wb && a3_wb != 0 && a3_wb == m_rt) ? wd_wb : m_rtd;
            idx  = int'(m_alu[11:2]);
            for (int lane = 0; lane < 4; lane++) begin
                if (m_st == 2'b01)
                    m_mem[idx][8*lane +: 8] = data[8*lane +: 8];
                else if (m_st == 2'b10 && (lane / 2) == int'(m_alu[1]))
                    m_mem[idx][8*lane +: 8] = data[8*(lane % 2) +: 8];
                else if (m_st == 2'b11 && lane == int'(m_alu[1:0]))
                    m_mem[idx][8*lane +: 8] = data[7:0];
            end
        end
        if (flush) model_bubble();
        else if (!stall) begin
            m_rw = RegWrite_ex; m_mtr = MemtoReg_ex; m_ld = Load_ex; m_st = Store_ex;
            m_alu = aluout_ex; m_rtd = rtdata_ex; m_rt = rt_ex; m_a3 = a3_ex; m_pc = pc_ex;
        end
    endtask

    task automatic set_nop();
        reset = 0; stall = 0; flush = 0;
        RegWrite_ex = 0; MemtoReg_ex = 0; Load_ex = 0; Store_ex = 0;
        aluout_ex = 0; rtdata_ex = 0; rt_ex = 0; a3_ex = 0; pc_ex = 0;
        RegWrite_wb = 0; a3_wb = 0; wd_wb = 0;
    endtask

    // One transaction: inputs are already driven; clock once and compare.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        n_txn++;
        $display("txn %0d: rst=%0b stl=%0b fl=%0b st=%0d alu=%08h -> alu_mem=%08h dm=%08h",
                 n_txn, reset, stall, flush, Store_ex, aluout_ex, aluout_mem, dmout_mem);
        chk("RegWrite_mem", 32'(RegWrite_mem), 32'(m_rw));
        chk("MemtoReg_mem", 32'(MemtoReg_mem), 32'(m_mtr));
        chk("Load_mem",     32'(Load_mem),     32'(m_ld));
        chk("a3_mem",       32'(a3_mem),       32'(m_a3));
        chk("pc_mem",       32'(pc_mem),       32'(m_pc));
        chk("aluout_mem",   aluout_mem,        m_alu);
        chk("dmout_mem",    dmout_mem,         m_mem[m_alu[11:2]]);
    endtask

    task automatic do_store(input logic [1:0] st, input logic [31:0] addr, input logic [31:0] data);
        set_nop();
        Store_ex = st; aluout_ex = addr; rtdata_ex = data;
        step();
    endtask

    task automatic do_load(input logic [31:0] addr);
        set_nop();
        Load_ex = 3'd1; RegWrite_ex = 1; a3_ex = 5'd3; aluout_ex = addr; MemtoReg_ex = 2'd1;
        step();
    endtask

    initial begin
        model_bubble();
        for (int w = 0; w < 1024; w++) m_mem[w] = 32'h0;
        set_nop();
        reset = 1;
        step();
        step();
        chk("reset_alu", aluout_mem, 32'h0);
        chk("reset_rw",  32'(RegWrite_mem), 32'h0);

        // Word store then read back one cycle after the write edge.
        do_store(2'b01, 32'h10, 32'hDEADBEEF);
        do_load(32'h10);
        chk("sw_readback", dmout_mem, 32'hDEADBEEF);

        // Byte and halfword merges into an existing word.
        do_store(2'b01, 32'h20, 32'h11223344);
        do_store(2'b11, 32'h23, 32'h000000AA);
        chk("sw_word", dmout_mem, 32'h11223344);
        do_store(2'b10, 32'h22, 32'h00005566);
        chk("sb_merge", dmout_mem, 32'hAA223344);
        do_load(32'h20);
        chk("sh_merge", dmout_mem, 32'h55663344);

        // Store-data forwarding from WB, and r0 never forwards.
        set_nop(); Store_ex = 2'b01; aluout_ex = 32'h40; rt_ex = 5'd8; rtdata_ex = 32'h1; step();
        set_nop(); aluout_ex = 32'h40; RegWrite_wb = 1; a3_wb = 5'd8; wd_wb = 32'h77; step();
        chk("fwd_taken", dmout_mem, 32'h77);
        set_nop(); Store_ex = 2'b01; aluout_ex = 32'h44; rt_ex = 5'd0; rtdata_ex = 32'h1; step();
        set_nop(); aluout_ex = 32'h44; RegWrite_wb = 1; a3_wb = 5'd0; wd_wb = 32'h77; step();
        chk("fwd_r0", dmout_mem, 32'h1);

        // Stall two cycles with a store latched: held, no write until release.
        do_store(2'b01, 32'h50, 32'h12345678);
        for (int i = 0; i < 2; i++) begin
            set_nop(); stall = 1; aluout_ex = 32'h99; step();
            chk("stall_hold_alu", aluout_mem, 32'h50);
            chk("stall_no_write", dmout_mem, 32'h0);
        end
        do_load(32'h50);
        chk("stall_release", dmout_mem, 32'h12345678);

        // Flush wins over stall.
        set_nop(); RegWrite_ex = 1; a3_ex = 5'd5; aluout_ex = 32'h8; step();
        set_nop(); flush = 1; stall = 1; RegWrite_ex = 1; a3_ex = 5'd6; step();
        chk("flush_rw", 32'(RegWrite_mem), 32'h0);
        chk("flush_a3", 32'(a3_mem), 32'h0);

        // Reset while a store sits in MEM: store suppressed, outputs cleared.
        do_store(2'b01, 32'h60, 32'hCAFEF00D);
        set_nop(); reset = 1; step();
        chk("rst_store_alu", aluout_mem, 32'h0);
        do_load(32'h60);
        chk("rst_store_word", dmout_mem, 32'h0);

        // Random traffic over a small address window to exercise read-after-write.
        for (int i = 0; i < 400; i++) begin
            set_nop();
            reset       = ($urandom_range(0, 63) == 0);
            stall       = ($urandom_range(0, 4) == 0);
            flush       = ($urandom_range(0, 7) == 0);
            RegWrite_ex = 1'($urandom);
            MemtoReg_ex = 2'($urandom);
            Load_ex     = 3'($urandom);
            Store_ex    = 2'($urandom);
            aluout_ex   = ($urandom & 32'hFFFF_F03F);
            rtdata_ex   = $urandom;
            rt_ex       = 5'($urandom_range(0, 3));
            a3_ex       = 5'($urandom);
            pc_ex       = 30'($urandom);
            RegWrite_wb = 1'($urandom);
            a3_wb       = 5'($urandom_range(0, 3));
            wd_wb       = $urandom;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
